usb_crc_engine: RTL
===================

// Module: usb_crc_engine
// PURPOSE
//  Parametrised, handshaked CRC generator/checker; successor to the fixed 8-bit-in usb_crc16.
//  Same engine serves CRC5 (token), CRC16 (data) and CRC32; polynomial, width, init, reflection
//  and XOR-out are set by parameter.
//  Data words are absorbed BITS_PER_CYC bits per clock. A word-level valid/ready handshake
//  lets the USB tx/rx datapath stall on it.
//  On the last word it presents the final CRC and a residue-check flag (crc_ok) for rx packets.
// PARAMETERS
//  CRC_W        16        CRC width, 5..32
//  POLY         16'h8005  generator polynomial, normal (MSB-first) form, implicit x^CRC_W omitted
//  INIT         16'hFFFF  register value loaded on reset and on start
//  XOROUT       16'hFFFF  XOR applied to the register to form crc_out
//  REFLECT_IN   1         1: consume in_data LSB first; 0: MSB first
//  REFLECT_OUT  1         1: bit-reverse the register before XOROUT
//  RESIDUE      16'hB001  good-packet register value (post-reflect, pre-XOROUT) tested by crc_ok
//  DATA_W       8         in_data width
//  BITS_PER_CYC 1         bits absorbed per clock; must divide DATA_W (elaboration $error otherwise)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       begin new message: reload INIT, abort any word in progress
//  in_valid   in   1       in_data/in_last valid
//  in_ready   out  1       engine can accept a word this cycle
//  in_data    in   DATA_W  data word
//  in_last    in   1       this word ends the message
//  busy       out  1       word being shifted
//  crc_valid  out  1       one-cycle pulse: crc_out/crc_ok updated for completed message
//  crc_out    out  CRC_W   final CRC (reflected per REFLECT_OUT, then ^XOROUT)
//  crc_ok     out  1       1 when final register == RESIDUE
// BEHAVIOUR
//  Reset: state IDLE, register=INIT, in_ready=1, busy=0, crc_valid=0, crc_out=0, crc_ok=0.
//  States:
//   - IDLE:  in_ready=1. A word is accepted on in_valid&&in_ready.
//            Word and in_last are latched; the bit counter loads DATA_W/BITS_PER_CYC.
//            Go to SHIFT, or stay IDLE when the count is 1.
//   - SHIFT: in_ready=0, busy=1. Each clock absorbs BITS_PER_CYC bits: feedback = reg[MSB]^bit,
//            then reg = {reg<<1} ^ (fb ? POLY : 0), repeated per bit.
//            Return to IDLE after the final slice.
//  Latency: word accepted at edge N -> register fully updated at edge N+DATA_W/BITS_PER_CYC.
//   - Default config: 8 clocks per byte; throughput 1 word per DATA_W/BITS_PER_CYC clocks.
//   - BITS_PER_CYC==DATA_W: in_ready stays 1; full rate of 1 word/clk.
//  Completion: the cycle after the final slice of a word with in_last=1:
//   - crc_valid=1 for exactly one clock.
//   - crc_out and crc_ok are registered and held until the next completion, start or reset.
//   - The register then reloads INIT, ready for the next message without start.
//  start: has priority over everything except rst.
//   - Register=INIT, counter cleared, state IDLE.
//   - A pending crc_valid is suppressed.
//   - crc_out/crc_ok are held (not cleared).
//  start && in_valid in the same cycle: start applies first. The word is accepted and hashed from INIT.
//  in_valid while in_ready=0: ignored. The source holds the word per valid/ready rules.
//  Message with a single word and in_last=1: legal; normal completion.
//  rst mid-word: immediate return to reset values. The partial word is discarded.
//  Widths:
//   - Register is CRC_W bits; POLY/INIT/XOROUT/RESIDUE are truncated to CRC_W.
//   - No arithmetic carries; all XOR.
// STRUCTURE
//  Shared package usb_crc_pkg:
//   - crc_state_t enum {IDLE, SHIFT}.
//   - Preset localparams: CRC5_USB, CRC16_USB and CRC32 values for POLY, INIT, XOROUT and RESIDUE.
//   - Function crc_step(reg, bit, poly) reused by the testbench reference model.
//  One sub-module, usb_crc_slice: combinational BITS_PER_CYC-bit update of the register.
//  The FSM, counter, data shifter and output registers live in the top.
// TESTING
//  1. CRC16 USB defaults: start, then ASCII "123456789" (last on '9').
//     -> crc_valid pulse; crc_out=16'hB4C8.
//  2. Rx check: "123456789" then bytes 8'hC8, 8'hB4 (last).
//     -> crc_ok=1, crc_out=16'h4FFE. Flip one bit -> crc_ok=0.
//  3. CRC5 USB (CRC_W=5, POLY=5'h05, INIT/XOROUT=5'h1F, RESIDUE=5'h06): "123456789" -> crc_out=5'h19.
//  4. CRC32 (POLY=32'h04C11DB7, INIT/XOROUT=32'hFFFFFFFF, RESIDUE=32'hDEBB20E3):
//     - BITS_PER_CYC=8: "123456789" -> crc_out=32'hCBF43926.
//     - in_ready never drops.
//  5. Abort: start mid-shift of byte 3 of a message, then "123456789".
//     -> exactly one crc_valid, value 16'hB4C8.
//     Same flow with rst instead -> reset values, then 16'hB4C8.
//  6. Backpressure: in_valid held high continuously with BITS_PER_CYC=1.
//     -> in_ready high 1 of every 8 clocks; result matches the scenario-1 value.

Source files
------------

// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg: shared types, CRC presets and bit-level helpers for usb_crc_engine.
//   crc_state_t  : engine FSM encoding (IDLE / SHIFT)
//   CRC*_USB_*   : POLY/INIT/XOROUT/RESIDUE presets (normal form, zero-extended to 32 bits)
//   crc_step     : one-bit LFSR update, also used by the testbench reference model
//   crc_reflect  : bit-reverse the low w bits of a value
package usb_crc_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} crc_state_t;

  localparam logic [31:0] CRC5_USB_POLY     = 32'h0000_0005;
  localparam logic [31:0] CRC5_USB_INIT     = 32'h0000_001F;
  localparam logic [31:0] CRC5_USB_XOROUT   = 32'h0000_001F;
  localparam logic [31:0] CRC5_USB_RESIDUE  = 32'h0000_0006;

  localparam logic [31:0] CRC16_USB_POLY    = 32'h0000_8005;
  localparam logic [31:0] CRC16_USB_INIT    = 32'h0000_FFFF;
  localparam logic [31:0] CRC16_USB_XOROUT  = 32'h0000_FFFF;
  localparam logic [31:0] CRC16_USB_RESIDUE = 32'h0000_B001;

  localparam logic [31:0] CRC32_POLY        = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT        = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE     = 32'hDEBB_20E3;

  // Register value lives in the low w bits; everything above is forced to zero.
  function automatic logic [31:0] crc_step(input logic [31:0] r, input logic b,
                                           input logic [31:0] poly, input int unsigned w);
    logic [31:0] mask;
    logic        fb;
    logic [31:0] n;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    fb   = (((r >> (w - 1)) & 32'd1) != 32'd0) ^ b;
    n    = (r << 1) ^ (fb ? poly : '0);
    return n & mask;
  endfunction

  function automatic logic [31:0] crc_reflect(input logic [31:0] r, input int unsigned w);
    logic [31:0] o;
    o = '0;
    for (int unsigned i = 0; i < w; i++) begin
      if (((r >> i) & 32'd1) != 32'd0) o = o | (32'd1 << (w - 1 - i));
    end
    return o;
  endfunction

endpackage

// File: rtl/usb_crc_engine_if.sv
// usb_crc_engine_if: word handshake and result bus of usb_crc_engine.
//   master (source/consumer side): drives start, in_valid, in_data, in_last;
//                                  observes in_ready, busy, crc_valid, crc_out, crc_ok
//   slave  (engine side)         : the mirror image
interface usb_crc_engine_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              busy;
  logic              crc_valid;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_ok;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, busy, crc_valid, crc_out, crc_ok
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, busy, crc_valid, crc_out, crc_ok
  );
endinterface

// File: rtl/usb_crc_slice.sv
// usb_crc_slice: combinational BITS_PER_CYC-bit update of a CRC_W-bit register.
//   crc_in   : current register value
//   bits     : slice to absorb, bits[0] is consumed first
//   crc_next : register after absorbing all slice bits
module usb_crc_slice
  import usb_crc_pkg::*;
#(
  parameter int          CRC_W        = 16,
  parameter logic [31:0] POLY         = 32'h0000_8005,
  parameter int          BITS_PER_CYC = 1
) (
  input  logic [CRC_W-1:0]        crc_in,
  input  logic [BITS_PER_CYC-1:0] bits,
  output logic [CRC_W-1:0]        crc_next
);

  localparam int unsigned CRC_WU = CRC_W;

  logic [31:0] acc;

  always_comb begin
    acc              = '0;
    acc[CRC_W-1:0]   = crc_in;
    for (int unsigned i = 0; i < BITS_PER_CYC; i++) begin
      acc = crc_step(acc, ((bits >> i) & BITS_PER_CYC'(1)) != '0, POLY, CRC_WU);
    end
    crc_next = acc[CRC_W-1:0];
  end

endmodule

// File: rtl/usb_crc_engine.sv
// usb_crc_engine: parametrised handshaked CRC generator/checker (CRC5/CRC16/CRC32).
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : usb_crc_engine_if slave -- start, in_valid/in_ready/in_data/in_last word
//              handshake, busy, and the crc_valid/crc_out/crc_ok result
// A word is latched on acceptance and absorbed BITS_PER_CYC bits per clock afterwards.
module usb_crc_engine
  import usb_crc_pkg::*;
#(
  parameter int          CRC_W        = 16,
  parameter logic [31:0] POLY         = 32'h0000_8005,
  parameter logic [31:0] INIT         = 32'h0000_FFFF,
  parameter logic [31:0] XOROUT       = 32'h0000_FFFF,
  parameter logic        REFLECT_IN   = 1'b1,
  parameter logic        REFLECT_OUT  = 1'b1,
  parameter logic [31:0] RESIDUE      = 32'h0000_B001,
  parameter int          DATA_W       = 8,
  parameter int          BITS_PER_CYC = 1
) (
  input logic         clk,
  input logic         rst,
  usb_crc_engine_if.slave bus
);

  localparam int unsigned SLICES = DATA_W / BITS_PER_CYC;
  localparam int unsigned CRC_WU = CRC_W;
  localparam int          CNT_W  = $clog2(SLICES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SLICES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CRC_W-1:0] INIT_W    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOROUT_W  = XOROUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RESIDUE_W = RESIDUE[CRC_W-1:0];

  if ((DATA_W % BITS_PER_CYC) != 0) begin : g_bpc_check
    $error("usb_crc_engine: BITS_PER_CYC must divide DATA_W");
  end
  if (CRC_W < 5 || CRC_W > 32) begin : g_width_check
    $error("usb_crc_engine: CRC_W must be within 5..32");
  end

  crc_state_t              state, state_next;
  logic [CRC_W-1:0]        crc_reg, crc_next, crc_refl;
  logic [DATA_W-1:0]       shreg, shreg_next;
  logic [BITS_PER_CYC-1:0] slice_bits;
  logic [CNT_W-1:0]        cnt;
  logic                    last_q, accept, absorb;

  assign accept = bus.in_valid && bus.in_ready;
  // A slice is absorbed whenever slices remain; the final one overlaps an IDLE cycle
  // so the next word can be accepted on the same edge (one word per SLICES clocks).
  assign absorb = (cnt != '0) && !bus.start;

  always_comb begin
    slice_bits = '0;
    shreg_next = shreg;
    if (REFLECT_IN) begin
      slice_bits = shreg[BITS_PER_CYC-1:0];
      shreg_next = shreg >> BITS_PER_CYC;
    end else begin
      slice_bits = {<<{shreg[DATA_W-1 -: BITS_PER_CYC]}};
      shreg_next = shreg << BITS_PER_CYC;
    end
  end

  usb_crc_slice #(
    .CRC_W       (CRC_W),
    .POLY        (POLY),
    .BITS_PER_CYC(BITS_PER_CYC)
  ) u_slice (
    .crc_in  (crc_reg),
    .bits    (slice_bits),
    .crc_next(crc_next)
  );

  assign crc_refl = REFLECT_OUT ? CRC_W'(crc_reflect(32'(crc_next), CRC_WU)) : crc_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (accept)         state_next = (SLICES == 1) ? IDLE : SHIFT;
    else if (bus.start) state_next = IDLE;
    else if (absorb)    state_next = (cnt > CNT_TWO) ? SHIFT : IDLE;
  end

  // Outputs; start makes the engine ready at once so a word presented with it is taken
  always_comb begin
    bus.in_ready = (state == IDLE) || bus.start;
    bus.busy     = (state == SHIFT);
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg       <= INIT_W;
      cnt           <= '0;
      shreg         <= '0;
      last_q        <= 1'b0;
      bus.crc_valid <= 1'b0;
      bus.crc_out   <= '0;
      bus.crc_ok    <= 1'b0;
    end else begin
      bus.crc_valid <= 1'b0;
      if (bus.start) begin
        crc_reg <= INIT_W;
        cnt     <= '0;
      end else if (absorb) begin
        cnt   <= cnt - CNT_ONE;
        shreg <= shreg_next;
        if (cnt == CNT_ONE && last_q) begin
          crc_reg       <= INIT_W;
          bus.crc_out   <= crc_refl ^ XOROUT_W;
          bus.crc_ok    <= (crc_refl == RESIDUE_W);
          bus.crc_valid <= 1'b1;
        end else begin
          crc_reg <= crc_next;
        end
      end
      if (accept) begin
        shreg  <= bus.in_data;
        last_q <= bus.in_last;
        cnt    <= CNT_LOAD;
      end
    end
  end

endmodule
